vec_mem_port: RTL
=================

VEC_MEM_PORT -- requirements
Module: vec_mem_port

Interface
REQ-001 Parameter NLANES, default 8: 64-bit-class words per vector request.
REQ-002 Parameter WORD_W, default 64: bits per lane word.
REQ-003 Parameter PORTS, default 2: lanes accessed per cycle; SHALL divide NLANES; BEATS = NLANES/PORTS.
REQ-004 Parameter DEPTH, default 1024: words in internal array; power of two; AW = log2(DEPTH).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when high with req_valid.
REQ-009 req_we  input  1  1 = vector write, 0 = vector read.
REQ-010 req_addr  input  AW  word index of lane 0.
REQ-011 req_stride  input  AW  unsigned word stride between lanes.
REQ-012 req_wdata  input  NLANES*WORD_W  lane i at bits [WORD_W*(i+1)-1 : WORD_W*i].
REQ-013 req_wmask  input  NLANES*WORD_W  per-bit write enable, same lane packing.
REQ-014 resp_valid  output  1  response present.
REQ-015 resp_ready  input  1  response consumed when high with resp_valid.
REQ-016 resp_we  output  1  echo of req_we of the completed request.
REQ-017 resp_rdata  output  NLANES*WORD_W  read data, same lane packing.

Function
REQ-018 FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE, resp_valid = 1 only in RESP.
REQ-019 IDLE & req_valid at edge: capture we/addr/stride/wdata/wmask, beat counter := 0, go BUSY.
REQ-020 BUSY beat k (k = 0..BEATS-1) at its edge: lanes i = k*PORTS .. k*PORTS+PORTS-1 access address (addr + i*stride) mod DEPTH.
REQ-021 Write beat: mem[a] := (mem[a] & ~mask_i) | (wdata_i & mask_i), committed at that edge; lane with all-zero mask leaves mem[a] unchanged.
REQ-022 Read beat: lane i of rdata buffer := mem[a] value before that edge's writes (none occur during reads).
REQ-023 After beat BEATS-1 edge: go RESP; resp_valid first visible BEATS cycles after the acceptance cycle (4 with defaults).
REQ-024 RESP & resp_ready at edge: go IDLE; resp_valid, resp_we, resp_rdata hold stable while resp_valid & !resp_ready.
REQ-025 Write response: resp_rdata = 0.
REQ-026 Address arithmetic modulo DEPTH (wrap-around); i*stride truncated to AW bits.
REQ-027 Aliasing lanes in one write (including stride 0): higher lane index wins for overlapping mask bits; lower lane bits not overlapped remain.
REQ-028 Aliasing lanes in one read: each lane returns the same stored word.
REQ-029 Request inputs ignored outside IDLE; no request overlap; new request accepted no earlier than the cycle after RESP handshake.
REQ-030 Memory contents are not initialised by reset; read of never-written word returns X in simulation, no other effect.

Reset
REQ-031 rst high at edge: state := IDLE, beat counter := 0, resp_valid := 0, resp_we := 0, resp_rdata := 0; req_ready = 0 while rst high.
REQ-032 rst mid-BUSY aborts request: beats already committed remain in memory, remaining beats never executed, no response produced.
REQ-033 rst has priority over every simultaneous handshake.

Verification
REQ-034 Unit-stride write addr=0x10 stride=1 lane i data=0x1111_0000+i, full mask, then read same -> resp_valid 4 cycles after each acceptance; read lane i = 0x1111_0000+i, resp_we=0.
REQ-035 Wrap: write addr=DEPTH-2 stride=3 -> lane i lands at (1022+3i) mod 1024, e.g. lane 1 at 1, lane 7 at 19; readback matches.
REQ-036 Partial mask: mem[5]=0xFFFF_FFFF_FFFF_FFFF, write lane0 addr 5 data 0 mask 0x0000_0000_FFFF_FFFF, other masks 0 -> mem[5]=0xFFFF_FFFF_0000_0000; other lane addresses unchanged.
REQ-037 Stride 0 write addr=7, lane i data=i, full masks -> mem[7]=7; stride 0 read returns 7 in all lanes.
REQ-038 Backpressure: hold resp_ready=0 for 10 cycles -> resp_valid and resp_rdata constant, req_ready=0 throughout; req_ready=1 the cycle after resp_ready handshake.
REQ-039 Reset after beat 1 of write addr=0x40 stride=1 -> lanes 0..3 written, lanes 4..7 old values, resp_valid never asserted, req_ready=1 cycle after rst deasserts.

Source files
------------

// File: rtl/vec_mem_port.sv
// ============================================================================
//  Module   : vec_mem_port
//  Purpose  : Strided vector load/store port onto a single internal word array,
//             servicing PORTS lanes per cycle over NLANES/PORTS beats.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mem_port #(
  parameter int NLANES = 8,
  parameter int WORD_W = 64,
  parameter int PORTS  = 2,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [AW-1:0]            req_addr,
  input  logic [AW-1:0]            req_stride,
  input  logic [NLANES*WORD_W-1:0] req_wdata,
  input  logic [NLANES*WORD_W-1:0] req_wmask,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_we,
  output logic [NLANES*WORD_W-1:0] resp_rdata
);

  localparam int BEATS = NLANES / PORTS;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = NLANES * WORD_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  logic [BW-1:0]       r_beat;
  logic                r_we;
  logic [AW-1:0]       r_addr;
  logic [AW-1:0]       r_stride;
  logic [VW-1:0]       r_wdata;
  logic [VW-1:0]       r_wmask;
  logic                r_resp_we;
  logic [WORD_W-1:0]   r_rbuf [NLANES];
  logic [WORD_W-1:0]   mem    [DEPTH];

  int                  w_lidx   [PORTS];
  logic [AW-1:0]       w_addr   [PORTS];
  logic [WORD_W-1:0]   w_wd     [PORTS];
  logic [WORD_W-1:0]   w_wm     [PORTS];
  logic [WORD_W-1:0]   w_merged [PORTS];

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_lidx[p] = int'(r_beat) * PORTS + p;
      w_addr[p] = r_addr + AW'(w_lidx[p]) * r_stride;
      w_wd[p]   = r_wdata[w_lidx[p]*WORD_W +: WORD_W];
      w_wm[p]   = r_wmask[w_lidx[p]*WORD_W +: WORD_W];
    end
  end

  // Lanes of one beat that alias the same word are folded together in lane
  // order, so the highest aliasing lane carries every earlier lane's bits.
  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      w_merged[p] = mem[w_addr[p]];
      for (int q = 0; q < PORTS; q++) begin
        if (q <= p && w_addr[q] == w_addr[p]) begin
          w_merged[p] = (w_merged[p] & ~w_wm[q]) | (w_wd[q] & w_wm[q]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == S_BUSY && r_we) begin
      for (int p = 0; p < PORTS; p++) begin
        mem[w_addr[p]] <= w_merged[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_beat    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_stride  <= '0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_resp_we <= 1'b0;
      for (int i = 0; i < NLANES; i++) begin
        r_rbuf[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_addr    <= req_addr;
            r_stride  <= req_stride;
            r_wdata   <= req_wdata;
            r_wmask   <= req_wmask;
            r_beat    <= '0;
            r_resp_we <= req_we;
            // Cleared here so a write response returns all-zero data.
            for (int i = 0; i < NLANES; i++) begin
              r_rbuf[i] <= '0;
            end
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (!r_we) begin
            for (int p = 0; p < PORTS; p++) begin
              r_rbuf[w_lidx[p]] <= mem[w_addr[p]];
            end
          end
          if (r_beat == BW'(BEATS - 1)) begin
            r_beat  <= '0;
            r_state <= S_RESP;
          end else begin
            r_beat  <= r_beat + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = (r_state == S_RESP);
  assign resp_we    = r_resp_we;

  for (genvar g = 0; g < NLANES; g++) begin : g_pack
    assign resp_rdata[g*WORD_W +: WORD_W] = r_rbuf[g];
  end

endmodule

`default_nettype wire
